// File: rtl/calib_sequencer.sv
// rtl/calib_sequencer.sv - offset calibration pass: average FIFO frames per channel, write offsets to EEPROM
module calib_sequencer #(
    parameter int unsigned AVG_LOG2    = 4,
    parameter logic [7:0]  BASE_ADDR   = 8'h00,
    parameter int unsigned ACK_TIMEOUT = 1023
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    output logic         fifo_aclr,
    output logic         fifo_rdreq,
    input  logic [7:0]   fifo_rdusedw,
    input  logic [127:0] fifo_q,
    output logic         ee_req,
    output logic [7:0]   ee_addr,
    output logic [7:0]   ee_wdata,
    input  logic         ee_ack,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [127:0] cal_offset
);
    localparam int ACC_W = 16 + AVG_LOG2;
    localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_WAIT, S_READ, S_ACC, S_AVG, S_WR, S_WR_ACK, S_GAP, S_DONE
    } state_t;

    state_t                  state_q;
    logic signed [ACC_W-1:0] acc_q [8];
    logic [AVG_LOG2-1:0]     frame_q;
    logic [3:0]              byte_q;
    logic [3:0]              byte_d;
    logic [TO_W-1:0]         to_cnt_q;
    logic                    fifo_aclr_q;
    logic                    fifo_rdreq_q;
    logic                    ee_req_q;
    logic [7:0]              ee_addr_q;
    logic [7:0]              ee_wdata_q;
    logic                    done_q;
    logic                    err_q;
    logic [127:0]            cal_offset_q;
    logic [127:0]            avg_d;

    // Byte k of the offset set: channel k/2, high byte on even k; matches the ch0-at-MSB packing.
    function automatic logic [7:0] byte_sel(input logic [127:0] v, input logic [3:0] k);
        return v[{4'd15 - k, 3'b000} +: 8];
    endfunction

    assign byte_d = byte_q + 4'd1;

    always_comb begin
        avg_d = '0;
        for (int i = 0; i < 8; i++) begin
            avg_d[16*(7-i) +: 16] = 16'(acc_q[i] >>> AVG_LOG2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            frame_q      <= '0;
            byte_q       <= '0;
            to_cnt_q     <= '0;
            fifo_aclr_q  <= 1'b0;
            fifo_rdreq_q <= 1'b0;
            ee_req_q     <= 1'b0;
            ee_addr_q    <= '0;
            ee_wdata_q   <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            cal_offset_q <= '0;
            for (int i = 0; i < 8; i++) acc_q[i] <= '0;
        end else begin
            fifo_aclr_q  <= 1'b0;
            fifo_rdreq_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            if (abort && state_q != S_IDLE) begin
                state_q  <= S_IDLE;
                ee_req_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            for (int i = 0; i < 8; i++) acc_q[i] <= '0;
                            frame_q     <= '0;
                            byte_q      <= '0;
                            fifo_aclr_q <= 1'b1;
                            state_q     <= S_CLEAR;
                        end
                    end
                    S_CLEAR: state_q <= S_WAIT;
                    S_WAIT: begin
                        if (fifo_rdusedw != 8'd0) begin
                            fifo_rdreq_q <= 1'b1;
                            state_q      <= S_READ;
                        end
                    end
                    S_READ: state_q <= S_ACC;
                    S_ACC: begin
                        for (int i = 0; i < 8; i++) begin
                            acc_q[i] <= acc_q[i] + ACC_W'($signed(fifo_q[16*(7-i) +: 16]));
                        end
                        frame_q <= frame_q + AVG_LOG2'(1);
                        state_q <= (frame_q == '1) ? S_AVG : S_WAIT;
                    end
                    S_AVG: begin
                        cal_offset_q <= avg_d;
                        ee_req_q     <= 1'b1;
                        ee_addr_q    <= BASE_ADDR + {4'd0, byte_q};
                        ee_wdata_q   <= byte_sel(avg_d, byte_q);
                        state_q      <= S_WR;
                    end
                    S_WR: begin
                        to_cnt_q <= '0;
                        if (ee_ack) begin
                            ee_req_q <= 1'b0;
                            state_q  <= S_GAP;
                        end else begin
                            state_q  <= S_WR_ACK;
                        end
                    end
                    S_WR_ACK: begin
                        if (ee_ack) begin
                            ee_req_q <= 1'b0;
                            state_q  <= S_GAP;
                        end else if (to_cnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
                            ee_req_q <= 1'b0;
                            err_q    <= 1'b1;
                            state_q  <= S_IDLE;
                        end else begin
                            to_cnt_q <= to_cnt_q + TO_W'(1);
                        end
                    end
                    S_GAP: begin
                        if (byte_q == 4'd15) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            byte_q     <= byte_d;
                            ee_req_q   <= 1'b1;
                            ee_addr_q  <= BASE_ADDR + {4'd0, byte_d};
                            ee_wdata_q <= byte_sel(cal_offset_q, byte_d);
                            state_q    <= S_WR;
                        end
                    end
                    S_DONE:  state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign fifo_aclr  = fifo_aclr_q;
    assign fifo_rdreq = fifo_rdreq_q;
    assign ee_req     = ee_req_q;
    assign ee_addr    = ee_addr_q;
    assign ee_wdata   = ee_wdata_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign err        = err_q;
    assign cal_offset = cal_offset_q;

endmodule

// File: tb/tb_calib_sequencer.sv
// tb/tb_calib_sequencer.sv - scoreboard bench for calib_sequencer with FIFO and EEPROM responders
module tb_calib_sequencer;
    localparam int         AVG_LOG2 = 2;
    localparam logic [7:0] BASE     = 8'hF8;
    localparam int         TO       = 40;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         fifo_aclr, fifo_rdreq;
    logic [7:0]   fifo_rdusedw;
    logic [127:0] fifo_q = '0;
    logic         ee_req;
    logic [7:0]   ee_addr, ee_wdata;
    logic         ee_ack = 1'b0;
    logic         busy, done, err;
    logic [127:0] cal_offset;

    typedef struct { logic [7:0] addr; logic [7:0] data; int k; } wr_t;
    typedef struct { bit is_err; logic [127:0] off; } evt_t;

    wr_t          exp_wr[$];
    evt_t         exp_evt[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [127:0] frame_tab [4];
    int           avail = 0;
    int           rd_ptr = 0;
    int           ack_mode = 0;
    logic [127:0] off_a, off_b, off_d, off_e;

    calib_sequencer #(.AVG_LOG2(AVG_LOG2), .BASE_ADDR(BASE), .ACK_TIMEOUT(TO)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .fifo_aclr(fifo_aclr), .fifo_rdreq(fifo_rdreq), .fifo_rdusedw(fifo_rdusedw), .fifo_q(fifo_q),
        .ee_req(ee_req), .ee_addr(ee_addr), .ee_wdata(ee_wdata), .ee_ack(ee_ack),
        .busy(busy), .done(done), .err(err), .cal_offset(cal_offset)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign fifo_rdusedw = (avail > rd_ptr) ? 8'(avail - rd_ptr) : 8'd0;

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [127:0] mk(input logic [15:0] l0, l1, l2, l3, l4, l5, l6, l7);
        return {l0, l1, l2, l3, l4, l5, l6, l7};
    endfunction

    function automatic int ack_delay(input int k);
        case (ack_mode)
            1:       return (k % 3 == 0) ? 0 : ((k % 3 == 1) ? 5 : TO);
            2:       return (k == 6) ? 100000 : 1;
            3:       return (k == 9) ? 20 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic push_pass(input logic [127:0] off, input int nwr, input int ev);
        for (int k = 0; k < nwr; k++) begin
            wr_t         w;
            logic [15:0] ch;
            ch     = off[16*(7 - k/2) +: 16];
            w.addr = BASE + 8'(k);
            w.data = (k % 2 == 0) ? ch[15:8] : ch[7:0];
            w.k    = k;
            exp_wr.push_back(w);
        end
        if (ev != 0) begin
            evt_t e;
            e.is_err = (ev == 2);
            e.off    = off;
            exp_evt.push_back(e);
        end
    endtask

    task automatic load(input logic [127:0] f0, f1, f2, f3);
        frame_tab[0] = f0; frame_tab[1] = f1; frame_tab[2] = f2; frame_tab[3] = f3;
        avail = 0;
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("busy_at_t1", 128'(busy), 128'(1));
        check("aclr_at_t1", 128'(fifo_aclr), 128'(1));
        @(negedge clk);
        check("aclr_one_cycle", 128'(fifo_aclr), 128'(0));
    endtask

    task automatic feed(input int pace);
        for (int f = 0; f < 4; f++) begin
            repeat (pace) @(negedge clk);
            avail = avail + 1;
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, 128'(busy), 128'(0));
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_ee_req"}, 128'(ee_req), 128'(0));
        check({tag, "_ee_addr"}, 128'(ee_addr), 128'(0));
        check({tag, "_ee_wdata"}, 128'(ee_wdata), 128'(0));
        check({tag, "_aclr"}, 128'(fifo_aclr), 128'(0));
        check({tag, "_rdreq"}, 128'(fifo_rdreq), 128'(0));
        check({tag, "_done"}, 128'(done), 128'(0));
        check({tag, "_err"}, 128'(err), 128'(0));
        check({tag, "_cal_offset"}, cal_offset, 128'(0));
    endtask

    // FIFO read side: rdreq in cycle c makes the next frame visible in cycle c+1.
    initial begin
        forever begin
            @(negedge clk);
            if (fifo_aclr) begin
                rd_ptr = 0;
            end else if (fifo_rdreq) begin
                @(posedge clk); #1;
                fifo_q = frame_tab[rd_ptr % 4];
                rd_ptr = rd_ptr + 1;
            end
        end
    end

    // EEPROM responder: ack in the d-th cycle after ee_req first appears, d from ack_mode.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk); #1;
            ee_ack = 1'b0;
            if (ee_req) begin
                if (cnt == ack_delay(int'(8'(ee_addr - BASE)))) begin
                    ee_ack = 1'b1;
                    cnt    = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        logic       prev_req, prev_done;
        logic [7:0] h_addr, h_data;
        int         last_acc, rise_cyc;
        wr_t        w;
        evt_t       e;
        prev_req = 1'b0; prev_done = 1'b0; last_acc = 0; rise_cyc = 0; h_addr = '0; h_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req  = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (prev_done) check("busy_after_done", 128'(busy), 128'(0));
                if (ee_req && !prev_req) begin
                    rise_cyc = cyc;
                    h_addr   = ee_addr;
                    h_data   = ee_wdata;
                    if (exp_wr.size() > 0 && exp_wr[0].k != 0)
                        check("gap_cycles", 128'(cyc - last_acc), 128'(2));
                end else if (ee_req) begin
                    check("addr_stable", 128'(ee_addr), 128'(h_addr));
                    check("data_stable", 128'(ee_wdata), 128'(h_data));
                end
                if (ee_req && ee_ack) begin
                    if (exp_wr.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_write: addr %h data %h", ee_addr, ee_wdata);
                    end else begin
                        w = exp_wr.pop_front();
                        check("wr_addr", 128'(ee_addr), 128'(w.addr));
                        check("wr_data", 128'(ee_wdata), 128'(w.data));
                    end
                    last_acc = cyc;
                end
                if (done || err) begin
                    if (exp_evt.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_event: done %b err %b", done, err);
                    end else begin
                        e = exp_evt.pop_front();
                        check("evt_is_err", 128'(err), 128'(e.is_err));
                        check("evt_cal_offset", cal_offset, e.off);
                        if (done) check("done_latency", 128'(cyc - last_acc), 128'(2));
                        if (err) begin
                            check("err_latency", 128'(cyc - rise_cyc), 128'(TO + 1));
                            check("err_req_low", 128'(ee_req), 128'(0));
                        end
                    end
                end
                prev_req  = ee_req;
                prev_done = done;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        off_a = mk(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
        off_b = mk(16'h0000, 16'h0000, 16'h0000, 16'hFFFD, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        off_d = mk(16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777);
        off_e = mk(16'h7FFF, 16'h8000, 16'h0002, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF);

        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // All lanes 0x0100, immediate acks.
        ack_mode = 0;
        load(off_a, off_a, off_a, off_a);
        push_pass(off_a, 16, 1);
        do_start();
        feed(1);
        wait_idle("pass_a_idle");
        check("pass_a_offset", cal_offset, off_a);

        // ch3 = -3,-2,-2,-2 floors to -3; acks delayed 0/5/40; start while busy ignored.
        ack_mode = 1;
        load(mk(16'h0, 16'h0, 16'h0, 16'hFFFD, 16'h0, 16'h0, 16'h0, 16'h0),
             mk(16'h0, 16'h0, 16'h0, 16'hFFFE, 16'h0, 16'h0, 16'h0, 16'h0),
             mk(16'h0, 16'h0, 16'h0, 16'hFFFE, 16'h0, 16'h0, 16'h0, 16'h0),
             mk(16'h0, 16'h0, 16'h0, 16'hFFFE, 16'h0, 16'h0, 16'h0, 16'h0));
        push_pass(off_b, 16, 1);
        do_start();
        feed(3);
        n = 0;
        while (!ee_req && n < 200) begin @(negedge clk); n++; end
        check("pass_b_req_seen", 128'(ee_req), 128'(1));
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("start_while_busy", 128'(busy), 128'(1));
        wait_idle("pass_b_idle");
        check("pass_b_offset", cal_offset, off_b);

        // Abort while waiting for the second frame.
        ack_mode = 0;
        load(off_a, off_a, off_a, off_a);
        do_start();
        avail = 1;
        n = 0;
        while (rd_ptr != 1 && n < 50) begin @(negedge clk); n++; end
        check("abort_first_read", 128'(rd_ptr), 128'(1));
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_rdreq", 128'(fifo_rdreq), 128'(0));
        check("abort_offset_kept", cal_offset, off_b);
        repeat (5) @(negedge clk);

        // No ack on byte 6: timeout, new offsets retained.
        ack_mode = 2;
        load(off_d, off_d, off_d, off_d);
        push_pass(off_d, 6, 2);
        do_start();
        feed(1);
        wait_idle("pass_d_idle");
        check("timeout_offset_kept", cal_offset, off_d);

        // Normal pass after the timeout, with signed extremes and flooring.
        ack_mode = 0;
        load(mk(16'h7FFF, 16'h8000, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF),
             mk(16'h7FFF, 16'h8000, 16'h0002, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0000),
             mk(16'h7FFF, 16'h8000, 16'h0003, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0000),
             mk(16'h7FFF, 16'h8000, 16'h0004, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0000));
        push_pass(off_e, 16, 1);
        do_start();
        feed(2);
        wait_idle("pass_e_idle");
        check("pass_e_offset", cal_offset, off_e);

        // Reset while byte 9 is outstanding.
        ack_mode = 3;
        avail = 0;
        push_pass(off_e, 9, 0);
        do_start();
        feed(1);
        n = 0;
        while (!(ee_req && ee_addr == BASE + 8'd9) && n < 300) begin @(negedge clk); n++; end
        check("byte9_requested", 128'(ee_req && ee_addr == BASE + 8'd9), 128'(1));
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midpass");
        check("reset_writes_drained", 128'(exp_wr.size()), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fresh pass rewrites all 16 bytes, addresses wrapping F8..FF, 00..07.
        ack_mode = 0;
        avail = 0;
        push_pass(off_e, 16, 1);
        do_start();
        feed(1);
        wait_idle("pass_f_idle");
        check("pass_f_offset", cal_offset, off_e);

        check("writes_outstanding", 128'(exp_wr.size()), 128'(0));
        check("events_outstanding", 128'(exp_evt.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
